vga_timing_monitor: RTL
=======================

# vga_timing_monitor

Receive-side checker for the VGA output path. Samples `vga_sync_h`, `vga_sync_v` and `vga_rgb` on the pixel strobe and measures line and frame timing against 640x480@60 parameters. It locks onto a conforming stream, flags timing violations, and produces a per-frame checksum of active-region pixels. The block sits beside the VGA driver for board self-test, and also serves as the scoreboard front end in driver testbenches.

## Interface
- `H_TOTAL`, 800: pixels per line
- `H_SYNC`, 96: hsync low width, pixels
- `H_BP`, 48: horizontal back porch
- `H_ACTIVE`, 640: active pixels per line
- `V_TOTAL`, 525: lines per frame
- `V_SYNC`, 2: vsync low width, lines
- `V_BP`, 33: vertical back porch, lines
- `V_ACTIVE`, 480: active lines
- `clk`  in  1  system clock, 50 MHz
- `rst_n`  in  1  reset, asynchronous, active-low
- `pixel_en`  in  1  one-`clk` strobe per pixel (every 2nd `clk` for 25 MHz); all sampling and counting only when high
- `vga_sync_h`  in  1  horizontal sync, active-low
- `vga_sync_v`  in  1  vertical sync, active-low
- `vga_rgb`  in  6  pixel `{R[1:0],G[1:0],B[1:0]}`
- `err_clr`  in  1  clears sticky error flags
- `locked`  out  1  high while in LOCKED
- `frame_done`  out  1  one-`clk` pulse per valid frame
- `frame_sum`  out  16  active-pixel checksum of last valid frame
- `frame_cnt`  out  8  valid-frame counter, wraps 255→0
- `h_err`  out  1  sticky horizontal violation
- `v_err`  out  1  sticky vertical violation

## Operation
- Stage 1, input capture: on `pixel_en`, register `s_h`, `s_v`, `s_rgb`, and keep the previous `s_h`/`s_v`.
- Edges: a fall is prev=1, now=0; a rise is prev=0, now=1. Edges are evaluated on `pixel_en` cycles only.
- `hcnt` (11 bit):
  - Set to 0 on an hsync fall.
  - Otherwise +1 per `pixel_en`, saturating at 2047.
  - Pixel positions: the fall sample is 0, and the first high sample is `H_SYNC`.
- `vcnt` (10 bit):
  - Set to 0 on a vsync fall. Vsync fall has priority over a same-sample hsync fall.
  - Otherwise +1 on each hsync fall, saturating at 1023.
- Horizontal checks, active in MEASURE and LOCKED, and only after the first hsync fall since entering MEASURE:
  - hsync fall with prior `hcnt` ≠ `H_TOTAL-1` → violation.
  - hsync rise with `hcnt` ≠ `H_SYNC` → violation.
- Vertical checks:
  - vsync fall with prior `vcnt` ≠ `V_TOTAL-1` → violation. Not checked on the SEARCH→MEASURE fall.
  - vsync rise with line count ≠ `V_SYNC` → violation. The line count includes a same-sample hsync fall.
- Active pixel: `vcnt` in [`V_SYNC+V_BP`, `V_SYNC+V_BP+V_ACTIVE`) and `hcnt` in [`H_SYNC+H_BP`, `H_SYNC+H_BP+H_ACTIVE`).
- Accumulator: on each active pixel, `acc += s_rgb` (zero-extended, mod 2^16). Cleared on every vsync fall.
- State machine:
  - SEARCH → MEASURE on a vsync fall.
  - MEASURE → LOCKED on a vsync fall if no violation occurred since entry; otherwise stay in MEASURE with the frame-error record cleared.
  - LOCKED → MEASURE on any violation, in the same cycle.
- Valid frame: a vsync fall in LOCKED, or in MEASURE with no violation.
  - Pulse `frame_done`.
  - Latch `frame_sum` from the final `acc`, including a same-sample active pixel (none occurs in a conforming stream).
  - Increment `frame_cnt`.
- Error flags:
  - A violation sets `h_err`/`v_err`.
  - `err_clr` clears them.
  - When a set and `err_clr` coincide, set wins.

## Timing
- Reset (async assert, sync release): state SEARCH; counters, `acc` and all outputs 0.
- Latency: an input change sampled on `pixel_en` strobe n is acted on at strobe n+1. Resulting output updates are visible from the `clk` after strobe n+1.
- `frame_done` is high for exactly one `clk`. `frame_sum` and `frame_cnt` change on the same edge that raises it.
- `locked` falls on the same edge that sets the error flag.
- Reset mid-frame: everything returns to SEARCH. Relock needs two vsync falls, i.e. one full clean frame.
- `pixel_en` low: all state frozen. Edges spanning gaps are still detected via the held prev values.

## Test plan
- Clean 640x480 stream, `pixel_en` every 2nd `clk`, rgb=6'h3F everywhere:
  - `locked`=1 after the 2nd vsync fall.
  - `frame_done` every 840000 `clk`.
  - `frame_sum`=16'h5000 (307200·63 mod 2^16); `frame_cnt` increments.
- Same stream, rgb=6'h01 in the active area and 6'h3F in blanking → `frame_sum`=16'hB000.
- One line of 801 pixels in a locked stream:
  - `h_err`=1 and `locked`=0 at that hsync fall.
  - No `frame_done` for that frame.
  - Relock at the end of the next clean frame.
- hsync low 95 pixels → `h_err`=1 at the rise. 524-line frame → `v_err`=1 at the vsync fall. `h_err` stays 0 for the 524-line case.
- `err_clr` asserted on the same `clk` as a violation → flag stays 1. `err_clr` alone later → 0.
- `rst_n` pulsed low mid-frame:
  - All outputs 0 immediately.
  - `locked` returns only after two further vsync falls.
  - `frame_cnt` restarts from 0.

Source files
------------

// File: rtl/vga_timing_monitor.sv
// Locks onto a 640x480@60 stream, flags sync timing violations and checksums active pixels per frame.
// Latency: sample at strobe n is acted on at strobe n+1. Backpressure: none, the monitor observes only.
module vga_timing_monitor #(
    parameter int H_TOTAL  = 800,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pixel_en,
    input  logic        vga_sync_h,
    input  logic        vga_sync_v,
    input  logic [5:0]  vga_rgb,
    input  logic        err_clr,
    output logic        locked,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic [7:0]  frame_cnt,
    output logic        h_err,
    output logic        v_err
);

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_RISE = 11'(H_SYNC);
    localparam logic [10:0] H_A0   = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_A1   = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_RISE = 10'(V_SYNC);
    localparam logic [9:0]  V_A0   = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_A1   = 10'(V_SYNC + V_BP + V_ACTIVE);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        s_h;
    logic        s_v;
    logic [5:0]  s_rgb;
    logic        p_h;
    logic        p_v;

    logic [10:0] hcnt;
    logic [10:0] hcnt_nxt;
    logic [9:0]  vcnt;
    logic [9:0]  vcnt_nxt;
    logic [9:0]  vcnt_inc;
    logic [9:0]  v_pos;
    logic [15:0] acc;
    logic [15:0] acc_fin;

    logic        h_armed;
    logic        frm_err;

    logic        h_fall;
    logic        h_rise;
    logic        v_fall;
    logic        v_rise;
    logic        measuring;
    logic        h_viol;
    logic        v_viol;
    logic        viol;
    logic        pix_active;
    logic        frame_valid;

    // Stage 1: input capture, previous levels kept for edge detection across pixel_en gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_h   <= 1'b0;
            s_v   <= 1'b0;
            s_rgb <= 6'd0;
            p_h   <= 1'b0;
            p_v   <= 1'b0;
        end else if (pixel_en) begin
            s_h   <= vga_sync_h;
            s_v   <= vga_sync_v;
            s_rgb <= vga_rgb;
            p_h   <= s_h;
            p_v   <= s_v;
        end
    end

    assign h_fall = pixel_en &  p_h & ~s_h;
    assign h_rise = pixel_en & ~p_h &  s_h;
    assign v_fall = pixel_en &  p_v & ~s_v;
    assign v_rise = pixel_en & ~p_v &  s_v;

    always_comb begin
        hcnt_nxt = (hcnt == 11'h7FF) ? hcnt : hcnt + 11'd1;
        if (h_fall) begin
            hcnt_nxt = 11'd0;
        end
        vcnt_inc = (vcnt == 10'h3FF) ? vcnt : vcnt + 10'd1;
        v_pos    = h_fall ? vcnt_inc : vcnt;
        vcnt_nxt = v_fall ? 10'd0 : v_pos;
    end

    // The pixel on a vsync-fall sample still belongs to the ending frame, so use v_pos, not vcnt_nxt.
    assign pix_active = pixel_en
                      & (v_pos >= V_A0) & (v_pos < V_A1)
                      & (hcnt_nxt >= H_A0) & (hcnt_nxt < H_A1);
    assign acc_fin    = acc + (pix_active ? {10'd0, s_rgb} : 16'd0);

    assign measuring = (state != SEARCH);
    assign h_viol    = measuring & h_armed
                     & ((h_fall & (hcnt != H_LAST)) | (h_rise & (hcnt_nxt != H_RISE)));
    assign v_viol    = measuring
                     & ((v_fall & (vcnt != V_LAST)) | (v_rise & (vcnt_nxt != V_RISE)));
    assign viol      = h_viol | v_viol;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= 11'd0;
            vcnt <= 10'd0;
            acc  <= 16'd0;
        end else if (pixel_en) begin
            hcnt <= hcnt_nxt;
            vcnt <= vcnt_nxt;
            acc  <= v_fall ? 16'd0 : acc_fin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH: begin
                if (v_fall) begin
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (v_fall && !viol && !frm_err) begin
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (viol) begin
                    state_nxt = MEASURE;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    always_comb begin
        locked      = (state == LOCKED);
        frame_valid = v_fall & ~viol
                    & ((state == LOCKED) | ((state == MEASURE) & ~frm_err));
    end

    // Horizontal checks arm on the first hsync fall after leaving SEARCH; the frame-error record
    // covers violations inside the frame now ending and restarts at every vsync fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_armed <= 1'b0;
            frm_err <= 1'b0;
        end else if (state_nxt == SEARCH) begin
            h_armed <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            if (h_fall) begin
                h_armed <= 1'b1;
            end
            if (v_fall) begin
                frm_err <= 1'b0;
            end else if (viol) begin
                frm_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            frame_sum  <= 16'd0;
            frame_cnt  <= 8'd0;
        end else begin
            frame_done <= frame_valid;
            if (frame_valid) begin
                frame_sum <= acc_fin;
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_err <= 1'b0;
            v_err <= 1'b0;
        end else begin
            if (h_viol) begin
                h_err <= 1'b1;
            end else if (err_clr) begin
                h_err <= 1'b0;
            end
            if (v_viol) begin
                v_err <= 1'b1;
            end else if (err_clr) begin
                v_err <= 1'b0;
            end
        end
    end

endmodule
